mem_burst_reader_writer: RTL and testbench

- Initiator-side controller for the single-port synchronous RAM, which registers its read address, so read data appears one cycle after the address is presented.
- Accepts word requests from the core over a valid/ready channel and drives the RAM's data, addr and we pins.
- Returns read data over a valid/ready response channel with backpressure.
- Supports single-word writes and incrementing read bursts.

---
 rtl/mem_burst_reader_writer_pkg.sv | 15 +
 rtl/mem_burst_reader_writer.sv | 108 ++++++++++
 tb/tb_mem_burst_reader_writer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_reader_writer_pkg.sv
// rtl/mem_burst_reader_writer_pkg.sv - shared types and default widths for the RAM burst controller
package mem_burst_reader_writer_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_LEN_WIDTH  = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      RD_ISSUE = 2'd2,
      RD_DATA  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_burst_reader_writer.sv
// rtl/mem_burst_reader_writer.sv - single-word writer and incrementing burst reader for a
// registered-address single-port RAM, with valid/ready request and response channels.
module mem_burst_reader_writer
   import mem_burst_reader_writer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   input  logic [LEN_WIDTH-1:0]  i_req_len,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic                  o_rsp_last,
   output logic                  o_busy,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_we,
   input  logic [DATA_WIDTH-1:0] i_mem_q
);

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [DATA_WIDTH-1:0] r_wdata_q;
   logic                  w_accept;
   logic                  w_rsp_fire;
   logic                  w_final_word;

   assign w_accept     = (r_state == IDLE) && i_req_valid;
   assign w_final_word = (r_remaining == '0);
   assign w_rsp_fire   = (r_state == RD_DATA) && i_rsp_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // The address is only advanced on a taken word, so a stalled RD_DATA keeps
   // the RAM re-reading the same location and mem_q stays stable.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_wdata_q   <= '0;
      end else if (w_accept) begin
         r_cur_addr <= i_req_addr;
         if (i_req_we) begin
            r_wdata_q <= i_req_wdata;
         end else begin
            r_remaining <= i_req_len;
         end
      end else if (w_rsp_fire && !w_final_word) begin
         r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(1);
         r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
   end

   always_comb begin
      w_next_state = r_state;
      o_req_ready  = 1'b0;
      o_rsp_valid  = 1'b0;
      o_rsp_last   = 1'b0;
      o_mem_we     = 1'b0;
      case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               w_next_state = i_req_we ? WRITE : RD_ISSUE;
            end
         end
         WRITE: begin
            o_mem_we     = 1'b1;
            w_next_state = IDLE;
         end
         RD_ISSUE: begin
            w_next_state = RD_DATA;
         end
         RD_DATA: begin
            o_rsp_valid = 1'b1;
            o_rsp_last  = w_final_word;
            if (i_rsp_ready) begin
               w_next_state = w_final_word ? IDLE : RD_ISSUE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign o_rsp_data = (r_state == RD_DATA) ? i_mem_q : '0;
   assign o_busy     = (r_state != IDLE);
   assign o_mem_addr = r_cur_addr;
   assign o_mem_data = r_wdata_q;

endmodule

// File: tb/tb_mem_burst_reader_writer.sv
// tb/tb_mem_burst_reader_writer.sv - scoreboard bench for mem_burst_reader_writer with a
// registered-address RAM model preloaded with addr ^ 0xA5A5.
module tb_mem_burst_reader_writer;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam int LW = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [LW-1:0] req_len;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_last;
   logic          busy;
   logic [DW-1:0] mem_data;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_q;

   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [AW-1:0] ram_addr_r;
   logic          ram_loaded = 1'b0;
   logic [DW-1:0] exp_mem [0:(1<<AW)-1];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int inv_bad = 0;

   exp_t          exp_q[$];
   logic [DW-1:0] obs_data[$];
   logic          obs_last[$];
   int            obs_cyc[$];
   logic [DW-1:0] stall_data[$];
   logic [AW-1:0] stall_addr[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < (1 << AW); i++) ram[i] <= DW'(i) ^ 16'hA5A5;
         ram_loaded <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_data;
      end
      ram_addr_r <= mem_addr;
   end
   assign mem_q = ram[ram_addr_r];

   always @(negedge clk) begin
      if ((rsp_valid && mem_we) || (rsp_valid && !busy)) inv_bad <= inv_bad + 1;
   end

   mem_burst_reader_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .i_req_len   (req_len),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_data  (rsp_data),
      .o_rsp_last  (rsp_last),
      .o_busy      (busy),
      .o_mem_data  (mem_data),
      .o_mem_addr  (mem_addr),
      .o_mem_we    (mem_we),
      .i_mem_q     (mem_q)
   );

   task automatic do_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Presents a request until accepted; pushes the expected read words to the scoreboard.
   task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [LW-1:0] len, output int acc_cyc, output bit ok);
      logic [AW-1:0] a;
      ok = 1'b0;
      acc_cyc = -1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_len = len;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            acc_cyc = cyc;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      if (we) begin
         exp_mem[addr] = wdata;
      end else begin
         for (int k = 0; k <= int'(len); k++) begin
            a = addr + AW'(k);
            exp_q.push_back(exp_t'{data: exp_mem[a], last: (k == int'(len))});
         end
      end
   endtask

   // Drives rsp_ready and records taken words; optionally stalls on one word.
   task automatic collect(input int n, input int stall_word, input int stall_n, input int max_cycles);
      int got = 0;
      int stalled = 0;
      obs_data.delete(); obs_last.delete(); obs_cyc.delete();
      stall_data.delete(); stall_addr.delete();
      for (int c = 0; c < max_cycles && got < n; c++) begin
         if (rsp_valid && got == stall_word && stalled < stall_n) begin
            rsp_ready = 1'b0;
            stalled++;
            stall_data.push_back(rsp_data);
            stall_addr.push_back(mem_addr);
         end else begin
            rsp_ready = 1'b1;
         end
         if (rsp_valid && rsp_ready) begin
            obs_data.push_back(rsp_data);
            obs_last.push_back(rsp_last);
            obs_cyc.push_back(cyc);
            got++;
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      total++; if (rsp_last !== 1'b0) begin bad++; $display("FAIL reset_rsp_last: got %b expected 0", rsp_last); end
      total++; if (mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_we_busy: got we=%b busy=%b expected 0 0", mem_we, busy); end
      total++; if (mem_addr !== '0 || mem_data !== '0) begin bad++; $display("FAIL reset_mem_pins: got addr=%h data=%h expected 0 0", mem_addr, mem_data); end
   endtask

   task automatic test_write_read();
      int acc;
      bit ok;
      exp_t e;
      send_req(1'b1, 10'h010, 16'h1234, '0, acc, ok);
      total++; if (!ok) begin bad++; $display("FAIL wr_accept: got timeout expected accept"); end
      total++; if (mem_we !== 1'b1 || mem_addr !== 10'h010 || mem_data !== 16'h1234 || req_ready !== 1'b0) begin
         bad++; $display("FAIL wr_pins: got we=%b addr=%h data=%h rdy=%b expected 1 010 1234 0", mem_we, mem_addr, mem_data, req_ready); end
      @(negedge clk);
      total++; if (busy !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL wr_done: got busy=%b we=%b expected 0 0", busy, mem_we); end
      total++; if (ram[10'h010] !== 16'h1234) begin bad++; $display("FAIL wr_ram: got %h expected 1234", ram[10'h010]); end
      send_req(1'b0, 10'h010, '0, 4'd0, acc, ok);
      collect(1, -1, 0, 20);
      total++; if (obs_data.size() != 1) begin bad++; $display("FAIL rd1_count: got %0d expected 1", obs_data.size()); end
      for (int k = 0; k < obs_data.size(); k++) begin
         e = exp_q.pop_front();
         total++; if (obs_data[k] !== e.data || obs_last[k] !== e.last) begin
            bad++; $display("FAIL rd1_word: got %h/%b expected %h/%b", obs_data[k], obs_last[k], e.data, e.last); end
      end
      if (obs_cyc.size() > 0) begin
         total++; if (obs_cyc[0] - acc != 2) begin bad++; $display("FAIL rd1_latency: got %0d expected 2", obs_cyc[0] - acc); end
      end
      exp_q.delete();
   endtask

   task automatic test_burst();
      int acc;
      bit ok;
      int gap_bad = 0;
      exp_t e;
      send_req(1'b0, 10'h020, '0, 4'd3, acc, ok);
      collect(4, -1, 0, 40);
      total++; if (obs_data.size() != 4) begin bad++; $display("FAIL burst_count: got %0d expected 4", obs_data.size()); end
      for (int k = 0; k < obs_data.size(); k++) begin
         e = exp_q.pop_front();
         total++; if (obs_data[k] !== e.data || obs_last[k] !== e.last) begin
            bad++; $display("FAIL burst_word%0d: got %h/%b expected %h/%b", k, obs_data[k], obs_last[k], e.data, e.last); end
         if (k > 0 && obs_cyc[k] - obs_cyc[k-1] != 2) gap_bad++;
      end
      total++; if (gap_bad != 0 || obs_cyc.size() == 0 || obs_cyc[0] - acc != 2) begin
         bad++; $display("FAIL burst_timing: got gap_errors=%0d expected 0 with first word 2 cycles after accept", gap_bad); end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      int acc;
      bit ok;
      int st_bad = 0;
      exp_t e;
      send_req(1'b0, 10'h020, '0, 4'd3, acc, ok);
      collect(4, 1, 5, 60);
      foreach (stall_data[i]) if (stall_data[i] !== 16'hA584 || stall_addr[i] !== 10'h021) st_bad++;
      total++; if (stall_data.size() != 5 || st_bad != 0) begin
         bad++; $display("FAIL bp_stable: got samples=%0d bad=%0d expected 5 0", stall_data.size(), st_bad); end
      total++; if (obs_data.size() != 4) begin bad++; $display("FAIL bp_count: got %0d expected 4", obs_data.size()); end
      for (int k = 0; k < obs_data.size(); k++) begin
         e = exp_q.pop_front();
         total++; if (obs_data[k] !== e.data || obs_last[k] !== e.last) begin
            bad++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b", k, obs_data[k], obs_last[k], e.data, e.last); end
      end
      exp_q.delete();
   endtask

   task automatic test_wrap();
      int acc;
      bit ok;
      exp_t e;
      send_req(1'b0, 10'h3FE, '0, 4'd2, acc, ok);
      collect(3, -1, 0, 40);
      total++; if (obs_data.size() != 3) begin bad++; $display("FAIL wrap_count: got %0d expected 3", obs_data.size()); end
      for (int k = 0; k < obs_data.size(); k++) begin
         e = exp_q.pop_front();
         total++; if (obs_data[k] !== e.data || obs_last[k] !== e.last) begin
            bad++; $display("FAIL wrap_word%0d: got %h/%b expected %h/%b", k, obs_data[k], obs_last[k], e.data, e.last); end
      end
      if (obs_cyc.size() > 0) begin
         total++; if (obs_cyc[0] - acc != 2) begin bad++; $display("FAIL wrap_latency: got %0d expected 2", obs_cyc[0] - acc); end
      end
      exp_q.delete();
   endtask

   task automatic test_busy();
      int acc;
      bit ok;
      int viol = 0;
      bit seen_idle = 1'b0;
      logic ready_at_idle = 1'b0;
      exp_t e;
      send_req(1'b0, 10'h040, '0, 4'd1, acc, ok);
      obs_data.delete(); obs_last.delete(); obs_cyc.delete();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h050; req_wdata = 16'h0BEE;
      for (int c = 0; c < 40 && !seen_idle; c++) begin
         if (busy) begin
            if (req_ready) viol++;
            if (rsp_valid) begin
               obs_data.push_back(rsp_data); obs_last.push_back(rsp_last); obs_cyc.push_back(cyc);
            end
            @(negedge clk);
         end else begin
            seen_idle = 1'b1;
            ready_at_idle = req_ready;
         end
      end
      total++; if (viol != 0 || !seen_idle) begin bad++; $display("FAIL busy_ready_low: got violations=%0d idle=%b expected 0 1", viol, seen_idle); end
      total++; if (ready_at_idle !== 1'b1) begin bad++; $display("FAIL busy_ready_idle: got %b expected 1", ready_at_idle); end
      @(negedge clk);
      req_valid = 1'b0;
      exp_mem[10'h050] = 16'h0BEE;
      total++; if (mem_we !== 1'b1 || mem_addr !== 10'h050 || mem_data !== 16'h0BEE) begin
         bad++; $display("FAIL busy_held_accept: got we=%b addr=%h data=%h expected 1 050 0bee", mem_we, mem_addr, mem_data); end
      total++; if (obs_data.size() != 2 || obs_cyc[0] - acc != 2) begin bad++; $display("FAIL busy_words: got %0d expected 2", obs_data.size()); end
      for (int k = 0; k < obs_data.size(); k++) begin
         e = exp_q.pop_front();
         total++; if (obs_data[k] !== e.data || obs_last[k] !== e.last) begin
            bad++; $display("FAIL busy_word%0d: got %h/%b expected %h/%b", k, obs_data[k], obs_last[k], e.data, e.last); end
      end
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int acc;
      bit ok;
      int first = -1;
      int diffs = 0;
      send_req(1'b0, 10'h060, '0, 4'd3, acc, ok);
      rsp_ready = 1'b0;
      for (int c = 0; c < 10 && first < 0; c++) begin
         if (rsp_valid) first = cyc;
         else @(negedge clk);
      end
      total++; if (first - acc != 2) begin bad++; $display("FAIL rstmid_reach: got %0d expected 2", first - acc); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
         bad++; $display("FAIL rstmid_async: got valid=%b busy=%b we=%b expected 0 0 0", rsp_valid, busy, mem_we); end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_release: got rdy=%b busy=%b expected 1 0", req_ready, busy); end
      for (int i = 0; i < (1 << AW); i++) if (ram[i] !== exp_mem[i]) diffs++;
      total++; if (diffs != 0) begin bad++; $display("FAIL rstmid_memory: got %0d differing words expected 0", diffs); end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) exp_mem[i] = DW'(i) ^ 16'hA5A5;
      test_reset();
      test_write_read();
      test_burst();
      test_backpressure();
      test_wrap();
      test_busy();
      test_reset_mid();
      total++; if (inv_bad != 0) begin bad++; $display("FAIL invariants: got %0d violations expected 0", inv_bad); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
